stack_port_sequencer: RTL

//  Owns the single data-memory port during multi-word stack sequences:

---
 rtl/stack_port_sequencer_if.sv | 47 ++++
 rtl/stack_port_sequencer.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/stack_port_sequencer_if.sv
// Stack sequencer port bundle: request channel, LSU channel, memory port, and sequence results.
// slave is the sequencer side; master is the core / memory side.
interface stack_port_sequencer_if #(
    parameter int ADDR_W = 12
);
    logic              req_valid;
    logic [2:0]        req_op;
    logic              req_ready;
    logic [15:0]       req_data;
    logic [31:0]       pc_in;
    logic [2:0]        flags_in;

    logic              lsu_req;
    logic              lsu_we;
    logic [ADDR_W-1:0] lsu_addr;
    logic [15:0]       lsu_wdata;
    logic              lsu_gnt;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;

    logic              busy;
    logic              done;
    logic [15:0]       pop_data;
    logic              pc_load;
    logic [31:0]       pc_out;
    logic              flags_load;
    logic [2:0]        flags_out;
    logic              stk_err;

    modport slave (
        input  req_valid, req_op, req_data, pc_in, flags_in,
        input  lsu_req, lsu_we, lsu_addr, lsu_wdata, mem_rdata,
        output req_ready, lsu_gnt, mem_en, mem_we, mem_addr, mem_wdata,
        output busy, done, pop_data, pc_load, pc_out, flags_load, flags_out, stk_err
    );

    modport master (
        output req_valid, req_op, req_data, pc_in, flags_in,
        output lsu_req, lsu_we, lsu_addr, lsu_wdata, mem_rdata,
        input  req_ready, lsu_gnt, mem_en, mem_we, mem_addr, mem_wdata,
        input  busy, done, pop_data, pc_load, pc_out, flags_load, flags_out, stk_err
    );
endinterface

// File: rtl/stack_port_sequencer.sv
// Runs PUSH/POP/CALL/INT/RET/RTI on the shared data port and owns SP; done 2..5 cycles after accept.
// LSU wins the port in IDLE; requests and LSU are both refused (held off) while a sequence runs.
module stack_port_sequencer #(
    parameter int                ADDR_W  = 12,
    parameter logic [ADDR_W-1:0] SP_INIT = {ADDR_W{1'b1}}
) (
    input  logic                   clk,
    input  logic                   reset,
    stack_port_sequencer_if.slave  bus
);
    localparam logic [2:0] OP_PUSH = 3'd0;
    localparam logic [2:0] OP_POP  = 3'd1;
    localparam logic [2:0] OP_CALL = 3'd2;
    localparam logic [2:0] OP_INT  = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;
    localparam logic [2:0] OP_RTI  = 3'd5;

    typedef enum logic [3:0] {
        S_IDLE, S_W_DATA, S_W_PCH, S_W_PCL, S_W_FLG,
        S_R_DATA, S_R_FLG, S_R_PCL, S_R_PCH, S_R_WAIT, S_DONE
    } state_t;

    state_t            r_state;
    logic [ADDR_W-1:0] r_sp;
    logic [2:0]        r_op;
    logic [15:0]       r_data;
    logic [31:0]       r_pc;
    logic [2:0]        r_flg_in;
    logic [15:0]       r_pop_lo;
    logic [2:0]        r_pop_flg;
    logic              r_busy, r_done, r_pc_load, r_flags_load, r_stk_err;
    logic [15:0]       r_pop_data;
    logic [31:0]       r_pc_out;
    logic [2:0]        r_flags_out;

    logic              w_idle, w_req_ready, w_lsu_gnt, w_accept;
    logic              w_is_pop, w_ovf;
    logic [ADDR_W-1:0] w_sp_inc, w_sp_dec;
    logic              w_en, w_we;
    logic [ADDR_W-1:0] w_addr;
    logic [15:0]       w_wdata;

    assign w_idle      = (r_state == S_IDLE) && !reset;
    assign w_lsu_gnt   = w_idle && bus.lsu_req;
    assign w_req_ready = w_idle && !bus.lsu_req && (bus.req_op <= OP_RTI);
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_sp_inc    = r_sp + ADDR_W'(1);
    assign w_sp_dec    = r_sp - ADDR_W'(1);
    assign w_is_pop    = (bus.req_op == OP_POP) || (bus.req_op == OP_RET) || (bus.req_op == OP_RTI);
    // Pushes write SP down to SP-(words-1); that last address must not wrap below zero.
    assign w_ovf       = ((bus.req_op == OP_CALL) && (r_sp == '0)) ||
                         ((bus.req_op == OP_INT)  && (r_sp <  ADDR_W'(2)));

    always_comb begin
        w_en    = 1'b0;
        w_we    = 1'b0;
        w_addr  = '0;
        w_wdata = '0;
        if (!reset) begin
            case (r_state)
                S_IDLE: if (bus.lsu_req) begin
                    w_en    = 1'b1;
                    w_we    = bus.lsu_we;
                    w_addr  = bus.lsu_addr;
                    w_wdata = bus.lsu_wdata;
                end
                S_W_DATA: begin w_en = 1'b1; w_we = 1'b1; w_addr = r_sp; w_wdata = r_data;          end
                S_W_PCH:  begin w_en = 1'b1; w_we = 1'b1; w_addr = r_sp; w_wdata = r_pc[31:16];     end
                S_W_PCL:  begin w_en = 1'b1; w_we = 1'b1; w_addr = r_sp; w_wdata = r_pc[15:0];      end
                S_W_FLG:  begin w_en = 1'b1; w_we = 1'b1; w_addr = r_sp; w_wdata = {13'b0, r_flg_in}; end
                S_R_DATA, S_R_FLG, S_R_PCL, S_R_PCH: begin
                    w_en   = 1'b1;
                    w_addr = w_sp_inc;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sp         <= SP_INIT;
            r_op         <= '0;
            r_data       <= '0;
            r_pc         <= '0;
            r_flg_in     <= '0;
            r_pop_lo     <= '0;
            r_pop_flg    <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_pc_load    <= 1'b0;
            r_flags_load <= 1'b0;
            r_stk_err    <= 1'b0;
            r_pop_data   <= '0;
            r_pc_out     <= '0;
            r_flags_out  <= '0;
        end else begin
            r_done       <= 1'b0;
            r_pc_load    <= 1'b0;
            r_flags_load <= 1'b0;
            r_stk_err    <= 1'b0;
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_op      <= bus.req_op;
                    r_data    <= bus.req_data;
                    r_pc      <= bus.pc_in;
                    r_flg_in  <= bus.flags_in;
                    r_busy    <= 1'b1;
                    r_stk_err <= (w_is_pop && (r_sp == SP_INIT)) || w_ovf;
                    case (bus.req_op)
                        OP_PUSH:         r_state <= S_W_DATA;
                        OP_POP:          r_state <= S_R_DATA;
                        OP_CALL, OP_INT: r_state <= S_W_PCH;
                        OP_RET:          r_state <= S_R_PCL;
                        default:         r_state <= S_R_FLG;
                    endcase
                end
                S_W_DATA: begin r_sp <= w_sp_dec; r_state <= S_DONE; r_done <= 1'b1; end
                S_W_PCH:  begin r_sp <= w_sp_dec; r_state <= S_W_PCL; end
                S_W_PCL: begin
                    r_sp <= w_sp_dec;
                    if (r_op == OP_INT) begin
                        r_state <= S_W_FLG;
                    end else begin
                        r_state <= S_DONE;
                        r_done  <= 1'b1;
                    end
                end
                S_W_FLG:  begin r_sp <= w_sp_dec; r_state <= S_DONE; r_done <= 1'b1; end
                S_R_DATA: begin r_sp <= w_sp_inc; r_state <= S_R_WAIT; end
                S_R_FLG:  begin r_sp <= w_sp_inc; r_state <= S_R_PCL; end
                // Read data trails its address by one cycle, so each read state captures its predecessor's word.
                S_R_PCL:  begin r_sp <= w_sp_inc; r_pop_flg <= bus.mem_rdata[2:0]; r_state <= S_R_PCH;  end
                S_R_PCH:  begin r_sp <= w_sp_inc; r_pop_lo  <= bus.mem_rdata;      r_state <= S_R_WAIT; end
                S_R_WAIT: begin
                    r_state <= S_DONE;
                    r_done  <= 1'b1;
                    if (r_op == OP_POP) begin
                        r_pop_data <= bus.mem_rdata;
                    end else begin
                        r_pc_load <= 1'b1;
                        r_pc_out  <= {bus.mem_rdata, r_pop_lo};
                        if (r_op == OP_RTI) begin
                            r_flags_load <= 1'b1;
                            r_flags_out  <= r_pop_flg;
                        end
                    end
                end
                default: begin r_state <= S_IDLE; r_busy <= 1'b0; end
            endcase
        end
    end

    assign bus.req_ready  = w_req_ready;
    assign bus.lsu_gnt    = w_lsu_gnt;
    assign bus.mem_en     = w_en;
    assign bus.mem_we     = w_we;
    assign bus.mem_addr   = w_addr;
    assign bus.mem_wdata  = w_wdata;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.pop_data   = r_pop_data;
    assign bus.pc_load    = r_pc_load;
    assign bus.pc_out     = r_pc_out;
    assign bus.flags_load = r_flags_load;
    assign bus.flags_out  = r_flags_out;
    assign bus.stk_err    = r_stk_err;
endmodule
